// File: rtl/mul54_share_arbiter_if.sv
// Bundle of both requester ports and the shared 54x54 multiply-add unit port.
// The arbiter takes the slave side; requesters and the multiplier take master.
interface mul54_share_arbiter_if #(
    parameter int A_W = 54,
    parameter int R_W = 105
);
    logic           req0_valid;
    logic           req0_ready;
    logic           req0_latch_a;
    logic [A_W-1:0] req0_a;
    logic           req0_latch_b;
    logic [A_W-1:0] req0_b;
    logic [R_W-1:0] req0_c;
    logic           req0_kill;
    logic           resp0_valid;
    logic [R_W-1:0] resp0_result;

    logic           req1_valid;
    logic           req1_ready;
    logic           req1_latch_a;
    logic [A_W-1:0] req1_a;
    logic           req1_latch_b;
    logic [A_W-1:0] req1_b;
    logic [R_W-1:0] req1_c;
    logic           req1_kill;
    logic           resp1_valid;
    logic [R_W-1:0] resp1_result;

    logic           mul_val_s0;
    logic           mul_latch_a_s0;
    logic [A_W-1:0] mul_a_s0;
    logic           mul_latch_b_s0;
    logic [A_W-1:0] mul_b_s0;
    logic [R_W-1:0] mul_c_s2;
    logic [R_W-1:0] mul_result_s3;

    modport slave (
        input  req0_valid, req0_latch_a, req0_a, req0_latch_b, req0_b, req0_c, req0_kill,
        output req0_ready, resp0_valid, resp0_result,
        input  req1_valid, req1_latch_a, req1_a, req1_latch_b, req1_b, req1_c, req1_kill,
        output req1_ready, resp1_valid, resp1_result,
        output mul_val_s0, mul_latch_a_s0, mul_a_s0, mul_latch_b_s0, mul_b_s0, mul_c_s2,
        input  mul_result_s3
    );

    modport master (
        output req0_valid, req0_latch_a, req0_a, req0_latch_b, req0_b, req0_c, req0_kill,
        input  req0_ready, resp0_valid, resp0_result,
        output req1_valid, req1_latch_a, req1_a, req1_latch_b, req1_b, req1_c, req1_kill,
        input  req1_ready, resp1_valid, resp1_result,
        input  mul_val_s0, mul_latch_a_s0, mul_a_s0, mul_latch_b_s0, mul_b_s0, mul_c_s2,
        output mul_result_s3
    );
endinterface

// File: rtl/mul54_share_arbiter.sv
// Two-port arbiter for a shared 3-stage 54x54 multiply-add unit: grants one issue
// per cycle, tags every in-flight op with its owner and routes addend/result by tag.
module mul54_share_arbiter #(
    parameter int A_W          = 54,
    parameter int R_W          = 105,
    parameter int STARVE_LIMIT = 4
) (
    input logic              clock,
    input logic              reset,
    mul54_share_arbiter_if.slave bus
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starveCnt;
    logic       lastOwner;
    logic       lastOwnerVld;
    logic       vld_p1, vld_p2, vld_p3;
    logic       id_p1, id_p2, id_p3;

    logic       fire0, fire1, fire, winner, sameOwner;
    logic       winLatchA, winLatchB;
    logic [1:0] killVec;

    function automatic logic [3:0] satInc(input logic [3:0] v);
        return (v >= LIMIT) ? v : v + 4'd1;
    endfunction

    // Stage 0: arbitration and issue; outputs are held quiet while reset is asserted
    always_comb begin
        fire0 = 1'b0;
        fire1 = 1'b0;
        if (!reset) begin
            fire0 = bus.req0_valid && !((starveCnt == LIMIT) && bus.req1_valid);
            fire1 = !fire0 && bus.req1_valid;
        end
    end

    assign fire      = fire0 || fire1;
    assign winner    = fire1;
    assign sameOwner = lastOwnerVld && (lastOwner == winner);
    assign winLatchA = fire1 ? bus.req1_latch_a : bus.req0_latch_a;
    assign winLatchB = fire1 ? bus.req1_latch_b : bus.req0_latch_b;
    assign killVec   = {bus.req1_kill, bus.req0_kill};

    assign bus.req0_ready     = fire0;
    assign bus.req1_ready     = fire1;
    assign bus.mul_val_s0     = fire;
    // A new owner cannot trust operands left in the multiplier by the other port
    assign bus.mul_latch_a_s0 = fire && (!sameOwner || winLatchA);
    assign bus.mul_latch_b_s0 = fire && (!sameOwner || winLatchB);
    assign bus.mul_a_s0       = reset ? '0 : (fire1 ? bus.req1_a : bus.req0_a);
    assign bus.mul_b_s0       = reset ? '0 : (fire1 ? bus.req1_b : bus.req0_b);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starveCnt    <= 4'd0;
            lastOwner    <= 1'b0;
            lastOwnerVld <= 1'b0;
            vld_p1       <= 1'b0;
            vld_p2       <= 1'b0;
            vld_p3       <= 1'b0;
            id_p1        <= 1'b0;
            id_p2        <= 1'b0;
            id_p3        <= 1'b0;
        end else begin
            // Tag pipe; a kill drops older entries only, never the op issuing now
            vld_p1 <= fire;
            id_p1  <= winner;
            vld_p2 <= vld_p1 && !killVec[id_p1];
            id_p2  <= id_p1;
            vld_p3 <= vld_p2 && !killVec[id_p2];
            id_p3  <= id_p2;

            if (fire1 || !bus.req1_valid) begin
                starveCnt <= 4'd0;
            end else if (fire0) begin
                starveCnt <= satInc(starveCnt);
            end

            if (fire) begin
                lastOwner    <= winner;
                lastOwnerVld <= 1'b1;
            end else if (killVec[lastOwner]) begin
                lastOwnerVld <= 1'b0;
            end
        end
    end

    // Stage 2: addend supplied by the owner of the op currently there
    always_comb begin
        bus.mul_c_s2 = '0;
        if (vld_p2) begin
            bus.mul_c_s2 = id_p2 ? bus.req1_c : bus.req0_c;
        end
    end

    // Stage 3: result steered to the owning port
    assign bus.resp0_valid  = vld_p3 && !id_p3;
    assign bus.resp1_valid  = vld_p3 && id_p3;
    assign bus.resp0_result = bus.resp0_valid ? bus.mul_result_s3 : '0;
    assign bus.resp1_result = bus.resp1_valid ? bus.mul_result_s3 : '0;
endmodule

// File: tb/tb_mul54_share_arbiter.sv
// Directed bench for mul54_share_arbiter with a behavioural 3-stage multiply-add model.
module tb_mul54_share_arbiter;
    localparam int A_W = 54;
    localparam int R_W = 105;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mul54_share_arbiter_if #(.A_W(A_W), .R_W(R_W)) bif ();

    mul54_share_arbiter #(.A_W(A_W), .R_W(R_W), .STARVE_LIMIT(4)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bif)
    );

    always #5 clock = ~clock;

    // Multiplier model: operand registers honour the latch flags, addend joins at stage 2
    logic [A_W-1:0] hA = '0, hB = '0, opA, opB;
    logic [R_W-1:0] m1 = '0, m2 = '0, m3 = '0;
    always @(posedge clock) begin
        if (bif.mul_val_s0) begin
            opA = bif.mul_latch_a_s0 ? bif.mul_a_s0 : hA;
            opB = bif.mul_latch_b_s0 ? bif.mul_b_s0 : hB;
            hA <= opA;
            hB <= opB;
            m1 <= R_W'(opA) * R_W'(opB);
        end
        m2 <= m1;
        m3 <= m2 + bif.mul_c_s2;
    end
    assign bif.mul_result_s3 = m3;

    typedef struct {
        logic r0v, r1v, l0a, l0b, l1a, l1b;
        logic [A_W-1:0] a0, b0, a1, b1;
        logic eR0, eR1, eVal, eLA, eLB;
        logic [A_W-1:0] eA, eB;
    } vec_t;
    vec_t tbl[9];

    task automatic check(input string name, input logic [R_W-1:0] act, input logic [R_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idleInputs();
        bif.req0_valid = 0; bif.req0_latch_a = 0; bif.req0_latch_b = 0; bif.req0_kill = 0;
        bif.req1_valid = 0; bif.req1_latch_a = 0; bif.req1_latch_b = 0; bif.req1_kill = 0;
        bif.req0_a = '0; bif.req0_b = '0; bif.req0_c = '0;
        bif.req1_a = '0; bif.req1_b = '0; bif.req1_c = '0;
    endtask

    task automatic issue0(input logic [A_W-1:0] a, input logic [A_W-1:0] b);
        bif.req0_valid = 1; bif.req0_latch_a = 1; bif.req0_latch_b = 1;
        bif.req0_a = a; bif.req0_b = b;
    endtask

    task automatic issue1(input logic [A_W-1:0] a, input logic [A_W-1:0] b);
        bif.req1_valid = 1; bif.req1_latch_a = 1; bif.req1_latch_b = 1;
        bif.req1_a = a; bif.req1_b = b;
    endtask

    initial begin
        // r0v r1v l0a l0b l1a l1b a0 b0 a1 b1 | eR0 eR1 eVal eLA eLB eA eB
        tbl[0] = '{1, 0, 0, 0, 0, 0, 11, 1, 99, 98, 1, 0, 1, 1, 1, 11, 1};
        tbl[1] = '{1, 0, 0, 1, 0, 0, 12, 2, 99, 98, 1, 0, 1, 0, 1, 12, 2};
        tbl[2] = '{0, 0, 0, 0, 0, 0, 13, 3, 99, 98, 0, 0, 0, 0, 0, 13, 3};
        tbl[3] = '{0, 1, 0, 0, 0, 0, 13, 3, 21, 31, 0, 1, 1, 1, 1, 21, 31};
        tbl[4] = '{0, 1, 0, 0, 1, 0, 13, 3, 22, 32, 0, 1, 1, 1, 0, 22, 32};
        tbl[5] = '{1, 1, 0, 0, 0, 0, 14, 4, 23, 33, 1, 0, 1, 1, 1, 14, 4};
        tbl[6] = '{1, 1, 0, 0, 0, 0, 15, 5, 23, 33, 1, 0, 1, 0, 0, 15, 5};
        tbl[7] = '{0, 1, 0, 0, 0, 1, 15, 5, 24, 34, 0, 1, 1, 1, 1, 24, 34};
        tbl[8] = '{0, 1, 0, 0, 0, 1, 15, 5, 25, 35, 0, 1, 1, 0, 1, 25, 35};

        idleInputs();
        bif.req0_valid = 1;
        bif.req0_a = 54'd9;
        #12;
        check("rst_ready0", R_W'(bif.req0_ready), 0);
        check("rst_mul_val", R_W'(bif.mul_val_s0), 0);
        check("rst_mul_a", R_W'(bif.mul_a_s0), 0);
        check("rst_resp0_valid", R_W'(bif.resp0_valid), 0);
        check("rst_mul_c", bif.mul_c_s2, 0);
        idleInputs();
        @(negedge clock);
        reset = 0;
        nextCycle();

        // Single port-0 op: 3*5+7 appears exactly three cycles after issue
        issue0(3, 5);
        bif.req0_c = 7;
        @(negedge clock);
        check("t1_ready0", R_W'(bif.req0_ready), 1);
        check("t1_latch_a", R_W'(bif.mul_latch_a_s0), 1);
        nextCycle();
        bif.req0_valid = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            check("t1_resp0_valid", R_W'(bif.resp0_valid), R_W'(c == 3));
            check("t1_mul_c", bif.mul_c_s2, (c == 2) ? R_W'(7) : R_W'(0));
            if (c == 3) check("t1_result", bif.resp0_result, 22);
            nextCycle();
        end

        // Starvation: with both ports busy port 1 wins every fifth cycle
        idleInputs();
        issue0(1, 1);
        issue1(2, 2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("starve_ready1", R_W'(bif.req1_ready), R_W'(i % 5 == 4));
            check("starve_ready0", R_W'(bif.req0_ready), R_W'(i % 5 != 4));
            nextCycle();
        end

        // Ownership change forces operand re-latch; same owner passes flags through
        for (int i = 0; i < 9; i++) begin
            bif.req0_valid = tbl[i].r0v; bif.req1_valid = tbl[i].r1v;
            bif.req0_latch_a = tbl[i].l0a; bif.req0_latch_b = tbl[i].l0b;
            bif.req1_latch_a = tbl[i].l1a; bif.req1_latch_b = tbl[i].l1b;
            bif.req0_a = tbl[i].a0; bif.req0_b = tbl[i].b0;
            bif.req1_a = tbl[i].a1; bif.req1_b = tbl[i].b1;
            @(negedge clock);
            check($sformatf("vec%0d_ready0", i), R_W'(bif.req0_ready), R_W'(tbl[i].eR0));
            check($sformatf("vec%0d_ready1", i), R_W'(bif.req1_ready), R_W'(tbl[i].eR1));
            check($sformatf("vec%0d_mul_val", i), R_W'(bif.mul_val_s0), R_W'(tbl[i].eVal));
            check($sformatf("vec%0d_latch_a", i), R_W'(bif.mul_latch_a_s0), R_W'(tbl[i].eLA));
            check($sformatf("vec%0d_latch_b", i), R_W'(bif.mul_latch_b_s0), R_W'(tbl[i].eLB));
            check($sformatf("vec%0d_mul_a", i), R_W'(bif.mul_a_s0), R_W'(tbl[i].eA));
            check($sformatf("vec%0d_mul_b", i), R_W'(bif.mul_b_s0), R_W'(tbl[i].eB));
            nextCycle();
        end
        idleInputs();
        repeat (4) nextCycle();

        // Interleaved owners 0,1,0 with per-owner addends 10,20,30
        for (int c = 0; c <= 5; c++) begin
            idleInputs();
            if (c == 0) issue0(2, 3);
            if (c == 1) issue1(4, 5);
            if (c == 2) issue0(6, 7);
            bif.req0_c = (c == 4) ? R_W'(30) : R_W'(10);
            bif.req1_c = R_W'(20);
            @(negedge clock);
            if (c == 2) check("il_c_s2_0", bif.mul_c_s2, 10);
            if (c == 3) check("il_c_s2_1", bif.mul_c_s2, 20);
            if (c == 4) check("il_c_s2_2", bif.mul_c_s2, 30);
            check("il_resp0_valid", R_W'(bif.resp0_valid), R_W'(c == 3 || c == 5));
            check("il_resp1_valid", R_W'(bif.resp1_valid), R_W'(c == 4));
            if (c == 3) check("il_result0", bif.resp0_result, 16);
            if (c == 4) check("il_result1", bif.resp1_result, 40);
            if (c == 5) check("il_result2", bif.resp0_result, 72);
            nextCycle();
        end
        idleInputs();
        repeat (3) nextCycle();

        // Kill of port 1 while a fresh port-0 op issues in the same cycle
        for (int c = 0; c <= 5; c++) begin
            idleInputs();
            bif.req0_c = 1;
            if (c == 0) issue1(2, 2);
            if (c == 1) begin
                issue0(3, 3);
                bif.req1_kill = 1;
            end
            @(negedge clock);
            if (c == 2) check("kill_c_s2", bif.mul_c_s2, 0);
            check("kill_resp1_valid", R_W'(bif.resp1_valid), 0);
            check("kill_resp0_valid", R_W'(bif.resp0_valid), R_W'(c == 4));
            if (c == 4) check("kill_result0", bif.resp0_result, 10);
            nextCycle();
        end
        idleInputs();
        repeat (2) nextCycle();

        // Asynchronous reset with three ops in flight
        issue0(1, 1);
        bif.req0_c = 5;
        repeat (3) nextCycle();
        @(negedge clock);
        check("rmid_resp0_before", R_W'(bif.resp0_valid), 1);
        #2;
        reset = 1;
        #1;
        check("rmid_ready0", R_W'(bif.req0_ready), 0);
        check("rmid_mul_val", R_W'(bif.mul_val_s0), 0);
        check("rmid_mul_a", R_W'(bif.mul_a_s0), 0);
        check("rmid_latch_a", R_W'(bif.mul_latch_a_s0), 0);
        check("rmid_resp0_valid", R_W'(bif.resp0_valid), 0);
        check("rmid_resp0_result", bif.resp0_result, 0);
        check("rmid_mul_c", bif.mul_c_s2, 0);
        nextCycle();
        idleInputs();
        @(negedge clock);
        reset = 0;
        for (int c = 0; c < 5; c++) begin
            nextCycle();
            @(negedge clock);
            check("rpost_resp0_valid", R_W'(bif.resp0_valid), 0);
            check("rpost_resp1_valid", R_W'(bif.resp1_valid), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul54_share_arbiter.md
Name: mul54_share_arbiter

Overview:
- Shares one pipelined 54x54 multiply-add unit between two requesters: port 0 is the div/sqrt iteration engine, port 1 is a secondary FP user.
- Grants at most one issue per cycle.
- Tracks ownership of every in-flight operation through the multiplier pipeline, so each requester gets its own addend at stage 2 and its own result at stage 3.
- Forces operand re-latch whenever multiplier ownership changes.

Parameters:
- A_W, 54, multiplier operand width.
- R_W, 105, addend and result width.
- STARVE_LIMIT, 4, consecutive port-1 denials before port 1 is forced to win; range 1..15.

Ports:
- clock  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  port-0 issue request
- req0_ready  out  1  port-0 issue accepted this cycle
- req0_latch_a  in  1  port-0 wants operand A latched
- req0_a  in  A_W  port-0 operand A
- req0_latch_b  in  1  port-0 wants operand B latched
- req0_b  in  A_W  port-0 operand B
- req0_c  in  R_W  port-0 addend, sampled at stage 2 of its op
- req0_kill  in  1  discard all port-0 in-flight ops
- resp0_valid  out  1  port-0 result valid
- resp0_result  out  R_W  port-0 result
- req1_valid, req1_ready, req1_latch_a, req1_a, req1_latch_b, req1_b, req1_c, req1_kill, resp1_valid, resp1_result: same widths and meanings as port 0, for port 1
- mul_val_s0  out  1  issue to multiplier
- mul_latch_a_s0  out  1  latch operand A
- mul_a_s0  out  A_W  operand A
- mul_latch_b_s0  out  1  latch operand B
- mul_b_s0  out  A_W  operand B
- mul_c_s2  out  R_W  addend for the op currently at stage 2
- mul_result_s3  in  R_W  multiplier result at stage 3

Behaviour:
- Reset (async): tag pipe cleared; starve_cnt=0; last_owner=0; last_owner_vld=0. Outputs: all ready/valid=0, mul_val_s0=0, latch flags 0, data outputs 0.
- Arbitration (combinational, same cycle):
  - Port 0 wins if req0_valid and not (starve_cnt==STARVE_LIMIT and req1_valid).
  - Otherwise port 1 wins if req1_valid.
  - reqN_ready=1 only for the winner; issue is the valid&ready fire.
- Issue: mul_val_s0=1; mul_a_s0/mul_b_s0 come from the winner.
  - If last_owner_vld and winner==last_owner: latch flags pass through from the winner.
  - Otherwise both latch flags are forced to 1.
  - last_owner and last_owner_vld=1 update on fire.
  - With no issue, mul_val_s0=0, latch flags 0, and operand buses hold the port-0 values.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) when req1_valid and port 0 wins.
  - Clears on port-1 fire, or when req1_valid=0.
- Tag pipe: stages s1, s2, s3, each holding {vld, id}.
  - s1 <= {fire, winner}; s2 <= s1; s3 <= s2.
  - Result latency from fire is exactly 3 cycles.
- mul_c_s2 = req(id of s2)_c when s2.vld, else 0.
- Response:
  - respN_valid = s3.vld and s3.id==N.
  - respN_result = mul_result_s3 when respN_valid, else 0.
  - Never both valid in the same cycle.
- Kill: reqN_kill clears vld of every s1/s2/s3 entry with id==N, registered at the next edge.
  - Same-cycle respN_valid is still reported, but killed at that edge.
  - If last_owner==N, last_owner_vld is cleared, forcing re-latch.
  - A fire in the same cycle as the kill is not killed.
- Back-to-back issue is allowed every cycle from either port. Interleaved ownership is allowed; each op routes by its own tag.
- Reset mid-operation discards all in-flight ops; no response is emitted afterwards.

Test Plan:
- Port 0 issues a=3, b=5, latch=1,1 at cycle 0; c=7 held; multiplier model returns a*b+c -> resp0_valid only at cycle 3, result 22; mul_c_s2=7 at cycle 2.
- Both ports valid continuously, STARVE_LIMIT=4 -> grant pattern 0,0,0,0,1 repeating; req1_ready is high exactly on every 5th cycle.
- Port 0 issues with latch_a=0 after a port-1 issue -> mul_latch_a_s0=1 forced. Port 0 issues with latch_a=0 again immediately -> mul_latch_a_s0=0 passes through.
- Alternating fires 0,1,0 with distinct c values 10, 20, 30 -> mul_c_s2 sequence 10, 20, 30 on cycles 2, 3, 4; resp0, resp1, resp0 on cycles 3, 4, 5 with matching results.
- Port 1 fires at cycle 0, req1_kill at cycle 1 -> no resp1_valid at cycle 3; a port-0 op fired at cycle 1 still responds at cycle 4.
- Reset asserted asynchronously mid-cycle with 3 ops in flight -> all outputs 0 immediately; no resp valid after reset release.
